// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared encodings for the SRAM left-port arbiter
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int REQ_R1    = 0;
  localparam int REQ_STACK = 1;
  localparam int REQ_RA    = 2;

  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// rtl/sram_port_arbiter_rr.sv - combinational one-hot pick, round-robin from ptr or fixed priority
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int RR_EN = 1,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (RR_EN != 0) ? PTR_W'((int'(ptr) + k) % N_REQ) : PTR_W'(k);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        any         = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - sequences one SRAM port access at a time for N_REQ requesters
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 4,
  parameter int ACCESS_CYCLES = 1,
  parameter int RR_EN         = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr_in,
  input  logic [N_REQ*DATA_W-1:0]   wr_data,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic                      CE,
  output logic                      OE,
  output logic                      RW,
  output logic [ADDR_W-1:0]         Addr,
  output logic [DATA_W-1:0]         dq_out,
  output logic                      dq_oe,
  input  logic [DATA_W-1:0]         dq_in
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t            state, state_d;
  logic [PTR_W-1:0]  ptr, next_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_any;
  logic [PTR_W-1:0]  arb_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N_REQ(N_REQ), .RR_EN(RR_EN)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .any   (arb_any),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_we   = we[i];
        sel_addr = addr_in[i*ADDR_W +: ADDR_W];
        sel_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (arb_any) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  if (cnt == '0) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes are driven from registers so the SRAM never sees combinational glitches
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr     <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      grant   <= '0;
      done    <= '0;
      rd_data <= '0;
      CE      <= STROBE_OFF;
      OE      <= STROBE_OFF;
      RW      <= STROBE_OFF;
      Addr    <= '0;
      dq_out  <= '0;
      dq_oe   <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant  <= arb_grant;
            we_q   <= sel_we;
            Addr   <= sel_addr;
            dq_out <= sel_data;
            dq_oe  <= sel_we;
            CE     <= 1'b0;
            if (RR_EN != 0) ptr <= next_ptr;
          end
        end
        ST_SETUP: begin
          cnt   <= CNT_LOAD;
          OE    <= we_q;
          RW    <= ~we_q;
          dq_oe <= we_q;
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            CE   <= STROBE_OFF;
            OE   <= STROBE_OFF;
            RW   <= STROBE_OFF;
            done <= grant;
            if (!we_q) rd_data <= dq_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          grant <= '0;
          dq_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed checks of the SRAM port arbiter in three configurations
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [11:0] addr_in = '0;
  logic [11:0] wr_data = '0;
  logic [3:0]  dq_in = '0;

  logic [2:0] grant_a, done_a, grant_b, done_b, grant_c, done_c;
  logic [3:0] rd_a, rd_b, rd_c, addr_a, addr_b, addr_c, dqo_a, dqo_b, dqo_c;
  logic       busy_a, ce_a, oe_a, rw_a, dqoe_a;
  logic       busy_b, ce_b, oe_b, rw_b, dqoe_b;
  logic       busy_c, ce_c, oe_c, rw_c, dqoe_c;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [2:0] exp_g;

  always #5 Clk = ~Clk;

  sram_port_arbiter u_a (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr_in(addr_in), .wr_data(wr_data),
    .grant(grant_a), .done(done_a), .rd_data(rd_a), .busy(busy_a), .CE(ce_a), .OE(oe_a),
    .RW(rw_a), .Addr(addr_a), .dq_out(dqo_a), .dq_oe(dqoe_a), .dq_in(dq_in)
  );

  sram_port_arbiter #(.RR_EN(0)) u_b (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr_in(addr_in), .wr_data(wr_data),
    .grant(grant_b), .done(done_b), .rd_data(rd_b), .busy(busy_b), .CE(ce_b), .OE(oe_b),
    .RW(rw_b), .Addr(addr_b), .dq_out(dqo_b), .dq_oe(dqoe_b), .dq_in(dq_in)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(3)) u_c (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr_in(addr_in), .wr_data(wr_data),
    .grant(grant_c), .done(done_c), .rd_data(rd_c), .busy(busy_c), .CE(ce_c), .OE(oe_c),
    .RW(rw_c), .Addr(addr_c), .dq_out(dqo_c), .dq_oe(dqoe_c), .dq_in(dq_in)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_all();
    req = '0;
    Rst = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    // Reset state: {CE,OE,RW,dq_oe}
    step();
    step();
    chk("rst strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b1110);
    chk("rst grant_done_busy", {grant_a, done_a, busy_a}, 7'b0);
    chk("rst addr_rd_dqout", {addr_a, rd_a, dqo_a}, 12'h000);

    // 1: single read by R1
    Rst = 1'b1;
    req = 3'(1 << REQ_R1);
    we = 3'b000;
    addr_in = 12'h005;
    dq_in = 4'hA;
    step();
    chk("t1 setup strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b0110);
    chk("t1 setup grant", grant_a, 3'b001);
    chk("t1 setup addr", addr_a, 4'h5);
    chk("t1 setup busy", busy_a, 1'b1);
    step();
    chk("t1 access strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b0010);
    chk("t1 access done", done_a, 3'b000);
    step();
    chk("t1 release strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b1110);
    chk("t1 release done", done_a, 3'b001);
    chk("t1 rd_data", rd_a, 4'hA);
    chk("t1 release addr", addr_a, 4'h5);
    req = '0;
    step();
    chk("t1 idle grant_done", {grant_a, done_a, busy_a}, 7'b0);
    step();
    step();
    step();

    // 2: write by stack
    req = 3'(1 << REQ_STACK);
    we = 3'b010;
    addr_in = 12'h0C0;
    wr_data = 12'h030;
    dq_in = 4'h7;
    step();
    chk("t2 setup strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b0111);
    chk("t2 setup grant", grant_a, 3'b010);
    chk("t2 addr_dqout", {addr_a, dqo_a}, 8'hC3);
    step();
    chk("t2 access strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b0101);
    step();
    chk("t2 release strobes", {ce_a, oe_a, rw_a, dqoe_a}, 4'b1111);
    chk("t2 release done", done_a, 3'b010);
    chk("t2 rd_data held", rd_a, 4'hA);
    req = '0;
    step();
    chk("t2 idle dq_oe_grant", {dqoe_a, grant_a}, 4'b0000);

    // 3: round-robin with all requests held
    reset_all();
    req = 3'b111;
    we = 3'b000;
    addr_in = 12'h987;
    for (int s = 1; s <= 13; s++) begin
      step();
      exp_g = (s % 4 == 0) ? 3'b000 : 3'(1 << (((s - 1) / 4) % 3));
      chk($sformatf("t3 grant s%0d", s), grant_a, exp_g);
      if (s % 4 == 1) chk($sformatf("t3 addr s%0d", s), addr_a, 16'(7 + ((s - 1) / 4) % 3));
    end

    // 4: fixed priority instance
    reset_all();
    req = 3'b110;
    step();
    chk("t4 first grant", grant_b, 3'b010);
    req = 3'b111;
    step();
    step();
    chk("t4 done1", done_b, 3'b010);
    step();
    chk("t4 idle gap", grant_b, 3'b000);
    step();
    chk("t4 second grant", grant_b, 3'b001);

    // 5: reset during ACCESS
    reset_all();
    req = 3'b001;
    we = 3'b000;
    addr_in = 12'h005;
    step();
    step();
    chk("t5 in access", {ce_a, oe_a}, 2'b00);
    #2;
    Rst = 1'b0;
    #1;
    chk("t5 async strobes", {ce_a, oe_a, rw_a}, 3'b111);
    chk("t5 async grant_busy", {grant_a, busy_a}, 4'b0);
    req = '0;
    step();
    chk("t5 no done", done_a, 3'b000);
    Rst = 1'b1;
    req = 3'(1 << REQ_RA);
    we = 3'b100;
    addr_in = 12'hE00;
    wr_data = 12'h600;
    step();
    chk("t5 regrant", grant_a, 3'b100);
    chk("t5 addr_dqout", {addr_a, dqo_a, dqoe_a}, 9'b1110_0110_1);
    step();
    step();
    chk("t5 done", done_a, 3'b100);

    // 6: three-cycle access, request dropped after SETUP
    reset_all();
    req = 3'b001;
    we = 3'b000;
    addr_in = 12'h003;
    dq_in = 4'h2;
    pulses = 0;
    step();
    pulses += int'(done_c[0]);
    chk("t6 setup grant", grant_c, 3'b001);
    req = '0;
    addr_in = 12'hFFF;
    step();
    pulses += int'(done_c[0]);
    chk("t6 access1", {ce_c, oe_c, rw_c, addr_c}, 7'b001_0011);
    step();
    pulses += int'(done_c[0]);
    chk("t6 access2 oe", oe_c, 1'b0);
    step();
    pulses += int'(done_c[0]);
    chk("t6 access3 oe", oe_c, 1'b0);
    chk("t6 rd before capture", rd_c, 4'h0);
    dq_in = 4'h9;
    step();
    pulses += int'(done_c[0]);
    chk("t6 release oe", oe_c, 1'b1);
    chk("t6 release done", done_c, 3'b001);
    chk("t6 rd_data", rd_c, 4'h9);
    step();
    pulses += int'(done_c[0]);
    chk("t6 idle grant", grant_c, 3'b000);
    step();
    pulses += int'(done_c[0]);
    chk("t6 stays idle", busy_c, 1'b0);
    chk("t6 one done pulse", 16'(pulses), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Arbitrates and sequences the single left port of the 16x4 register/stack SRAM between three requesters: 0 = R1 register access, 1 = stack push/pop, 2 = return-address save/restore.
It generates the active-low CE/OE/RW strobes, the address and the write-data drive enable, over a fixed multi-cycle access.
It returns read data and a one-cycle done pulse to the granted requester.
It sits between CONTROL/SRAM addressing logic and the SRAM left port, and replaces direct strobe generation.

Parameters:
N_REQ, 3, number of requesters (index 0..N_REQ-1)
ADDR_W, 4, SRAM address width
DATA_W, 4, SRAM data width
ACCESS_CYCLES, 1, cycles OE/RW held active (1..4)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (index 0 highest)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester access request, level, held until done
we  in  N_REQ  per-requester write (1) / read (0)
addr_in  in  N_REQ*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
wr_data  in  N_REQ*DATA_W  per-requester write data, same packing
grant  out  N_REQ  one-hot; high from SETUP through RELEASE
done  out  N_REQ  one-cycle completion pulse to the granted requester
rd_data  out  DATA_W  captured read data, valid from the done cycle until the next capture
busy  out  1  high in any state other than IDLE
CE  out  1  SRAM chip enable, active-low
OE  out  1  SRAM output enable, active-low
RW  out  1  SRAM read/write, low = write
Addr  out  ADDR_W  SRAM address
dq_out  out  DATA_W  write data to the SRAM data pins
dq_oe  out  1  tristate enable for dq_out, active-high
dq_in  in  DATA_W  SRAM read data

Behaviour:
- Reset (Rst low, asynchronous):
  - state = IDLE; CE = OE = RW = 1.
  - Addr = 0, dq_out = 0, dq_oe = 0.
  - grant = 0, done = 0, rd_data = 0, busy = 0.
  - Round-robin pointer = 0.
  - Reset mid-access aborts immediately: strobes return high in the same instant, and no done pulse is issued.
- FSM states: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles) -> RELEASE -> IDLE.
- IDLE:
  - Arbitration happens only here.
  - If any req bit is set, the winner's we/addr/wr_data are latched into internal registers on the edge.
  - grant[winner] is set and the FSM moves to SETUP.
  - If no req bit is set, the FSM stays in IDLE.
- SETUP (1 cycle): CE = 0, Addr = latched address, OE = 1, RW = 1; dq_oe = latched we, with dq_out valid.
- ACCESS:
  - CE = 0.
  - Read: OE = 0. Write: RW = 0, dq_oe = 1.
  - An internal down-counter sized for ACCESS_CYCLES sets the length.
  - On the final ACCESS edge, for a read, dq_in is captured into rd_data.
- RELEASE (1 cycle):
  - CE = OE = RW = 1; Addr held.
  - dq_oe is held for a write (data hold time).
  - done[granted] = 1.
  - On exit: grant = 0, dq_oe = 0.
- Latency: req seen at edge k gives done high in cycle k+2+ACCESS_CYCLES; the access occupies 3+ACCESS_CYCLES cycles including the IDLE arbitration cycle. Back-to-back grants are separated by exactly one IDLE cycle.
- Round-robin (RR_EN = 1):
  - The search starts at the pointer and proceeds in increasing index order, mod N_REQ.
  - After granting i, the pointer becomes (i+1) mod N_REQ.
- Fixed priority (RR_EN = 0): the lowest set index wins; the pointer is unused.
- A req that drops while granted does not abort the access; the access completes and done still pulses.
- Changes to addr_in/wr_data/we after latching are ignored.
- A requester that keeps req high after its done is treated as a new request in the following IDLE.
- CE, OE, RW, Addr and dq_oe are registered outputs (glitch-free). OE and RW are never low simultaneously.

Decomposition:
- Shared package: state encoding constants (IDLE, SETUP, ACCESS, RELEASE), requester index constants (REQ_R1 = 0, REQ_STACK = 1, REQ_RA = 2), and strobe inactive level (1'b1).
- One natural sub-module: rr_arbiter. It is combinational one-hot pick from req plus pointer, with an RR_EN bypass, and is reusable for the bus-A driver arbiter.

Test Plan:
1. Reset then single read: req = 3'b001, we = 0, addr_in[3:0] = 4'h5, dq_in = 4'hA -> expected response:
   - CE low for 2 cycles (ACCESS_CYCLES = 1), OE low 1 cycle, Addr = 5.
   - done[0] pulses at cycle k+3, rd_data = 4'hA, RW never low.
2. Write by stack: req = 3'b010, we = 3'b010, addr_in[7:4] = 4'hC, wr_data[7:4] = 4'h3 -> expected response:
   - RW low 1 cycle with CE low, dq_oe high SETUP..RELEASE, dq_out = 3, OE stays high.
   - done[1] pulses; rd_data unchanged.
3. Round-robin: req = 3'b111 held continuously -> grants sequence 001, 010, 100, 001, each separated by one IDLE cycle.
4. Fixed priority (RR_EN = 0), req = 3'b110 then 3'b111 -> grant to index 1 first, then index 0 while req[0] stays asserted.
5. Reset mid-access: assert Rst low during ACCESS -> CE/OE/RW return high asynchronously, grant = 0, no done; the next req is serviced normally.
6. ACCESS_CYCLES = 3, read while req drops after SETUP -> OE low 3 cycles, rd_data captured on the last ACCESS edge, done still pulses once.
